// File: rtl/snake_dir_pkg.sv
// Direction encodings and helpers shared by the snake direction input path.
// One-hot bit map: [0]=UP [1]=DOWN [2]=LEFT [3]=RIGHT.
package snake_dir_pkg;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    // 10 ms at 25 MHz; counter width covers the full legal range up to 2^20-1.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEBOUNCE_CNT_W          = 20;

    function automatic logic [3:0] opposite_dir(input logic [3:0] dir);
        logic [3:0] opp;
        case (dir)
            DIR_UP:    opp = DIR_DOWN;
            DIR_DOWN:  opp = DIR_UP;
            DIR_LEFT:  opp = DIR_RIGHT;
            DIR_RIGHT: opp = DIR_LEFT;
            default:   opp = 4'b0000;
        endcase
        return opp;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button: two-flop synchroniser, stability counter, and a
// one-cycle press pulse on each debounced rising edge.
module button_debouncer
    import snake_dir_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                      sync1_q, sync2_q;
    logic                      db_q, db_d;
    logic                      db_prev_q;
    logic [DEBOUNCE_CNT_W-1:0] cnt_q, cnt_d;

    // Any sample equal to the current level restarts the stability count.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
        end
    end

    assign level = db_q;
    assign press = db_q & ~db_prev_q;

endmodule

// File: rtl/snake_dir_input.sv
// Debounced button presses -> validated, tick-committed one-hot snake direction.
// Optional SNAKE_DIR_PAUSE_EN adds a pause button that blanks move_dir.
module snake_dir_input
    import snake_dir_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [3:0]  INIT_DIR        = DIR_RIGHT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       step_tick,
`ifdef SNAKE_DIR_PAUSE_EN
    input  logic       btn_pause,
`endif
    output logic [3:0] move_dir,
    output logic       dir_changed,
    output logic       req_pending
);

    logic [3:0] dir_press;
    logic [3:0] unused_level;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (btn_raw[i]),
            .level (unused_level[i]),
            .press (dir_press[i])
        );
    end

    logic paused;
    logic pause_toggle;

`ifdef SNAKE_DIR_PAUSE_EN
    logic paused_q;
    logic unused_pause_level;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_pause),
        .level (unused_pause_level),
        .press (pause_toggle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            paused_q <= 1'b0;
        end else if (pause_toggle) begin
            paused_q <= ~paused_q;
        end
    end

    assign paused = paused_q;
`else
    assign paused       = 1'b0;
    assign pause_toggle = 1'b0;
`endif

    logic [3:0] dir_q, dir_d;
    logic [3:0] pending_q, pending_d;
    logic       req_pending_q, req_pending_d;
    logic       dir_changed_q, dir_changed_d;
    logic [3:0] cand;
    logic       commit;
    logic       accept_now;
    logic       accept_post;

    // A request is latched into pending and only becomes move_dir on a
    // step_tick, so two presses within one step can never reverse the snake.
    always_comb begin
        cand = 4'b0000;
        if      (dir_press[0]) cand = DIR_UP;
        else if (dir_press[1]) cand = DIR_DOWN;
        else if (dir_press[2]) cand = DIR_LEFT;
        else if (dir_press[3]) cand = DIR_RIGHT;

        commit      = step_tick && req_pending_q && !paused;
        accept_now  = (cand != 4'b0000) && (cand != dir_q)
                      && (cand != opposite_dir(dir_q)) && !paused;
        accept_post = (cand != pending_q) && (cand != opposite_dir(pending_q));

        dir_d         = dir_q;
        pending_d     = pending_q;
        req_pending_d = req_pending_q;
        dir_changed_d = 1'b0;

        if (commit) begin
            dir_d         = pending_q;
            dir_changed_d = 1'b1;
            req_pending_d = 1'b0;
        end

        // On a commit edge the new press must also be legal against the
        // direction being committed, otherwise it is dropped.
        if (accept_now && (!commit || accept_post)) begin
            pending_d     = cand;
            req_pending_d = 1'b1;
        end

        if (pause_toggle && paused) begin
            dir_changed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q         <= INIT_DIR;
            pending_q     <= 4'b0000;
            req_pending_q <= 1'b0;
            dir_changed_q <= 1'b0;
        end else begin
            dir_q         <= dir_d;
            pending_q     <= pending_d;
            req_pending_q <= req_pending_d;
            dir_changed_q <= dir_changed_d;
        end
    end

    assign move_dir    = paused ? 4'b0000 : dir_q;
    assign dir_changed = dir_changed_q;
    assign req_pending = req_pending_q;

endmodule

// File: doc/snake_dir_input.md
Name: snake_dir_input

Overview:
- Upstream stage of the VGA/snake display path; produces the 4-bit `move_dir` consumed by the display controller and snake logic.
- Synchronises and debounces four push-buttons and converts presses into a one-hot direction request.
- Rejects 180° reversals and commits the new direction only on the game-step tick, so the snake cannot reverse through two quick presses within one step.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable `clk` cycles required before a debounced level changes (10 ms at 25 MHz); legal range 2..2^20-1.
- INIT_DIR, 4'b1000, committed direction after reset (RIGHT).

Ports:
- clk  input  1  pixel/system clock
- reset  input  1  reset, synchronous, active-high
- btn_raw  input  4  asynchronous buttons, active-high; [0]=UP [1]=DOWN [2]=LEFT [3]=RIGHT
- step_tick  input  1  one-cycle pulse marking a snake movement step
- move_dir  output  4  committed direction, one-hot, same bit map as btn_raw
- dir_changed  output  1  one-cycle pulse when move_dir takes a new value
- req_pending  output  1  a validated request is waiting for step_tick

Behaviour:
- Reset values (synchronous, active-high reset):
  - move_dir=INIT_DIR; dir_changed=0; req_pending=0.
  - All synchroniser flops, debounce counters and debounced levels are 0.
  - The pending register is cleared. Reset mid-debounce discards the partial count.
- Synchroniser: two flops per button; btn_sync is btn_raw delayed 2 cycles.
- Debounce, per button:
  - Counter cnt and level db.
  - If btn_sync==db: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: db<=btn_sync, cnt<=0.
  - Else cnt<=cnt+1.
  - Result: db follows a raw change held steady for DEBOUNCE_CYCLES+2 cycles. Any glitch back to the db value restarts the count.
- Press detect: press[i]=db[i]&~db_q[i]; one cycle per debounced rising edge. Releases are ignored.
- Arbitration: if several press bits assert in the same cycle, priority is UP>DOWN>LEFT>RIGHT. Exactly one candidate is taken per cycle.
- Validation against the current move_dir:
  - Opposite direction (UP<->DOWN, LEFT<->RIGHT): discarded.
  - Same direction: discarded.
  - Otherwise: written to the pending register, and req_pending<=1.
  - A later valid press before step_tick overwrites the pending value (last valid press wins).
- Commit: on a cycle with step_tick=1 and req_pending=1:
  - move_dir<=pending; dir_changed<=1 on the same edge; req_pending<=0.
  - dir_changed is high for exactly the one cycle after that edge.
- Simultaneous press and step_tick in one cycle: the commit uses the pending value held before that edge. The new press is validated against the pre-commit move_dir, and it is loaded as the new pending only if it is also valid against the committed value; otherwise it is dropped.
- step_tick with no pending request: no change, dir_changed=0.
- move_dir is always exactly one-hot outside the optional pause state.

Optional Feature:
- Macro: SNAKE_DIR_PAUSE_EN.
- Defined:
  - Adds input btn_pause (1 bit, same sync/debounce path).
  - Each debounced press toggles internal paused, reset value 0.
  - While paused, move_dir drives 4'b0000 and the stored direction is held.
  - Direction presses while paused are discarded; step_tick is ignored.
  - Unpausing restores the stored direction, with dir_changed pulsing once.
- Undefined: no btn_pause port and no pause logic; move_dir is never zero.

Decomposition:
- Package snake_dir_pkg:
  - Constants DIR_UP=4'b0001, DIR_DOWN=4'b0010, DIR_LEFT=4'b0100, DIR_RIGHT=4'b1000.
  - Function for the opposite direction.
  - Default DEBOUNCE_CYCLES value.
- Sub-module button_debouncer:
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, reset, raw, level, press.
  - Contains the synchroniser, counter and edge detect.
  - Instantiated 4 times (5 with SNAKE_DIR_PAUSE_EN).

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then idle 20 cycles -> move_dir=4'b1000, dir_changed=0, req_pending=0.
2. Hold btn_raw=4'b0001 for 10 cycles, then pulse step_tick -> req_pending=1 at 7 cycles after the raw change; move_dir=4'b0001 after the tick edge; dir_changed high exactly 1 cycle.
3. From RIGHT, press LEFT (4'b0100) then step_tick -> press discarded; req_pending=0; move_dir stays 4'b1000.
4. Raw glitch: btn[1] high for 3 cycles, low 1 cycle, repeated -> db never sets; no pending request.
5. From RIGHT, press UP then press LEFT (UP released, LEFT held steady) before the tick -> pending=UP then LEFT; LEFT is valid against the committed RIGHT? No, it is the opposite, so it is discarded. Commit gives move_dir=4'b0001. Repeat with UP then DOWN -> commit DOWN=4'b0010.
6. btn_raw=4'b0101 held simultaneously from RIGHT -> UP wins by priority; after step_tick move_dir=4'b0001. With SNAKE_DIR_PAUSE_EN: a pause press gives move_dir=4'b0000; a second pause press restores 4'b0001 with one dir_changed pulse.
